sim_queue_interface: RTL and testbench

Parametrised, buffered simulation host interface for the wishbone master. Sits between the testbench-side simulation driver and the master's input/output handshake ports. Queues inbound commands in a FIFO and issues them to the master one at a time under an FSM handshake. Captures master responses into a second FIFO that the simulation side drains with valid/ready.

---
 rtl/sim_queue_pkg.sv | 16 +
 rtl/sim_queue_fifo.sv | 63 ++++++
 rtl/sim_queue_interface.sv | 154 +++++++++++++++
 tb/tb_sim_queue_interface.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_queue_pkg.sv
// Shared definitions for the simulation host queue interface: issue FSM
// state encoding and default widths.
package sim_queue_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_COUNT_WIDTH    = 28;
    localparam int DEF_IN_DEPTH_LOG2  = 2;
    localparam int DEF_OUT_DEPTH_LOG2 = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } issue_state_t;

endpackage

// File: rtl/sim_queue_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags and a flush.
// A push while full is accepted only when a pop frees the slot the same cycle.
module sim_queue_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   next_count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        next_count = count;
        if (do_push && !do_pop)
            next_count = count + COUNT_ONE;
        else if (do_pop && !do_push)
            next_count = count - COUNT_ONE;
    end

    // NOTE: storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= next_count;
        end
    end

endmodule

// File: rtl/sim_queue_interface.sv
// Buffered simulation host interface for the wishbone master: inbound command
// FIFO with issue FSM, outbound response FIFO. Optional trace: SIM_QUEUE_TRACE_EN.
module sim_queue_interface
    import sim_queue_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH,
    parameter int IN_DEPTH_LOG2  = DEF_IN_DEPTH_LOG2,
    parameter int OUT_DEPTH_LOG2 = DEF_OUT_DEPTH_LOG2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_sim_in_reset,
    input  logic                   i_sim_in_valid,
    output logic                   o_sim_in_ready,
    input  logic [DATA_WIDTH-1:0]  i_sim_in_command,
    input  logic [DATA_WIDTH-1:0]  i_sim_in_address,
    input  logic [DATA_WIDTH-1:0]  i_sim_in_data,
    input  logic [COUNT_WIDTH-1:0] i_sim_in_data_count,
    output logic                   o_sim_out_valid,
    input  logic                   i_sim_out_ready,
    output logic [DATA_WIDTH-1:0]  o_sim_out_status,
    output logic [DATA_WIDTH-1:0]  o_sim_out_address,
    output logic [DATA_WIDTH-1:0]  o_sim_out_data,
    output logic [COUNT_WIDTH-1:0] o_sim_out_data_count,
    output logic                   o_overflow,
    input  logic                   i_master_ready,
    output logic                   o_ih_reset,
    output logic                   o_ih_ready,
    output logic [DATA_WIDTH-1:0]  o_in_command,
    output logic [DATA_WIDTH-1:0]  o_in_address,
    output logic [DATA_WIDTH-1:0]  o_in_data,
    output logic [COUNT_WIDTH-1:0] o_in_data_count,
    output logic                   o_oh_ready,
    input  logic                   i_oh_en,
    input  logic [DATA_WIDTH-1:0]  i_out_status,
    input  logic [DATA_WIDTH-1:0]  i_out_address,
    input  logic [DATA_WIDTH-1:0]  i_out_data,
    input  logic [COUNT_WIDTH-1:0] i_out_data_count
);

    localparam int WORD_WIDTH = 3 * DATA_WIDTH + COUNT_WIDTH;

    issue_state_t          state;
    logic [WORD_WIDTH-1:0] in_head;
    logic [WORD_WIDTH-1:0] out_head;
    logic                  in_full;
    logic                  in_empty;
    logic                  out_full;
    logic                  out_empty;
    logic                  in_pop;

    assign in_pop = (state == IDLE) & ~in_empty & i_master_ready & ~i_sim_in_reset;

    sim_queue_fifo #(
        .WIDTH      (WORD_WIDTH),
        .DEPTH_LOG2 (IN_DEPTH_LOG2)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (i_sim_in_reset),
        .push  (i_sim_in_valid),
        .pop   (in_pop),
        .wdata ({i_sim_in_command, i_sim_in_address, i_sim_in_data, i_sim_in_data_count}),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty)
    );

    sim_queue_fifo #(
        .WIDTH      (WORD_WIDTH),
        .DEPTH_LOG2 (OUT_DEPTH_LOG2)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (i_sim_in_reset),
        .push  (i_oh_en),
        .pop   (i_sim_out_ready),
        .wdata ({i_out_status, i_out_address, i_out_data, i_out_data_count}),
        .rdata (out_head),
        .full  (out_full),
        .empty (out_empty)
    );

    assign o_sim_in_ready  = ~in_full;
    assign o_oh_ready      = ~out_full;
    assign o_sim_out_valid = ~out_empty;

    // Present zeros rather than stale storage when nothing is queued.
    assign {o_sim_out_status, o_sim_out_address, o_sim_out_data, o_sim_out_data_count} =
        out_empty ? '0 : out_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_ih_ready   <= 1'b0;
            o_ih_reset   <= 1'b0;
            o_in_command <= '0;
            o_in_address <= '0;
            o_in_data    <= '0;
            o_in_data_count <= '0;
        end else begin
            o_ih_reset <= i_sim_in_reset;
            o_ih_ready <= 1'b0;
            if (i_sim_in_reset) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_pop) begin
                            {o_in_command, o_in_address, o_in_data, o_in_data_count} <= in_head;
                            state <= STROBE;
                        end
                    end
                    STROBE: begin
                        o_ih_ready <= 1'b1;
                        state      <= HOLD;
                    end
                    // The master keeps ready high until it has taken the command.
                    HOLD: begin
                        if (!i_master_ready)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A response is dropped only when the FIFO is full and no pop frees a slot.
    always_ff @(posedge clk) begin
        if (rst || i_sim_in_reset)
            o_overflow <= 1'b0;
        else if (i_oh_en && out_full && !i_sim_out_ready)
            o_overflow <= 1'b1;
    end

`ifdef SIM_QUEUE_TRACE_EN
    always @(posedge clk) begin
        if (!rst && !i_sim_in_reset) begin
            if (state == STROBE)
                $display("[%0t] sim_queue issue: command=%h address=%h data=%h",
                         $time, o_in_command, o_in_address, o_in_data);
            if (i_oh_en && (!out_full || i_sim_out_ready))
                $display("[%0t] sim_queue response: status=%h address=%h data=%h",
                         $time, i_out_status, i_out_address, i_out_data);
            else if (i_oh_en)
                $display("[%0t] sim_queue WARNING: response dropped, outbound queue full",
                         $time);
        end
    end
`endif

endmodule

// File: tb/tb_sim_queue_interface.sv
// Self-checking bench for sim_queue_interface: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sim_queue_interface;

    localparam int DW    = 32;
    localparam int CW    = 28;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [CW-1:0] n;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_sim_in_reset;
    logic          i_sim_in_valid;
    logic          o_sim_in_ready;
    logic [DW-1:0] i_sim_in_command, i_sim_in_address, i_sim_in_data;
    logic [CW-1:0] i_sim_in_data_count;
    logic          o_sim_out_valid;
    logic          i_sim_out_ready;
    logic [DW-1:0] o_sim_out_status, o_sim_out_address, o_sim_out_data;
    logic [CW-1:0] o_sim_out_data_count;
    logic          o_overflow;
    logic          i_master_ready;
    logic          o_ih_reset;
    logic          o_ih_ready;
    logic [DW-1:0] o_in_command, o_in_address, o_in_data;
    logic [CW-1:0] o_in_data_count;
    logic          o_oh_ready;
    logic          i_oh_en;
    logic [DW-1:0] i_out_status, i_out_address, i_out_data;
    logic [CW-1:0] i_out_data_count;

    sim_queue_interface dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_sim_in_reset       (i_sim_in_reset),
        .i_sim_in_valid       (i_sim_in_valid),
        .o_sim_in_ready       (o_sim_in_ready),
        .i_sim_in_command     (i_sim_in_command),
        .i_sim_in_address     (i_sim_in_address),
        .i_sim_in_data        (i_sim_in_data),
        .i_sim_in_data_count  (i_sim_in_data_count),
        .o_sim_out_valid      (o_sim_out_valid),
        .i_sim_out_ready      (i_sim_out_ready),
        .o_sim_out_status     (o_sim_out_status),
        .o_sim_out_address    (o_sim_out_address),
        .o_sim_out_data       (o_sim_out_data),
        .o_sim_out_data_count (o_sim_out_data_count),
        .o_overflow           (o_overflow),
        .i_master_ready       (i_master_ready),
        .o_ih_reset           (o_ih_reset),
        .o_ih_ready           (o_ih_ready),
        .o_in_command         (o_in_command),
        .o_in_address         (o_in_address),
        .o_in_data            (o_in_data),
        .o_in_data_count      (o_in_data_count),
        .o_oh_ready           (o_oh_ready),
        .i_oh_en              (i_oh_en),
        .i_out_status         (i_out_status),
        .i_out_address        (i_out_address),
        .i_out_data           (i_out_data),
        .i_out_data_count     (i_out_data_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queues for both FIFOs plus the issue handshake rules.
    word_t in_q[$];
    word_t out_q[$];
    word_t exp_in;
    bit    exp_ih_ready, exp_ih_reset, exp_ovf;
    bit    strobe_due, waiting;

    // NOTE: the model is an ordinary procedure, so it updates its variables with
    // blocking assignments in the order the rules are applied.
    always @(posedge clk) begin
        if (rst) begin
            in_q.delete();
            out_q.delete();
            exp_in       = '0;
            exp_ih_ready = 1'b0;
            exp_ih_reset = 1'b0;
            exp_ovf      = 1'b0;
            strobe_due   = 1'b0;
            waiting      = 1'b0;
        end else begin
            exp_ih_reset = i_sim_in_reset;
            if (i_sim_in_reset) begin
                in_q.delete();
                out_q.delete();
                exp_ovf      = 1'b0;
                exp_ih_ready = 1'b0;
                strobe_due   = 1'b0;
                waiting      = 1'b0;
            end else begin
                exp_ih_ready = strobe_due;
                if (strobe_due) begin
                    strobe_due = 1'b0;
                    waiting    = 1'b1;
                end else if (waiting) begin
                    if (!i_master_ready) waiting = 1'b0;
                end else if (in_q.size() > 0 && i_master_ready) begin
                    exp_in     = in_q.pop_front();
                    strobe_due = 1'b1;
                end
                if (i_sim_in_valid && in_q.size() < DEPTH)
                    in_q.push_back({i_sim_in_command, i_sim_in_address, i_sim_in_data,
                                    i_sim_in_data_count});
                if (out_q.size() > 0 && i_sim_out_ready)
                    void'(out_q.pop_front());
                if (i_oh_en) begin
                    if (out_q.size() < DEPTH)
                        out_q.push_back({i_out_status, i_out_address, i_out_data,
                                         i_out_data_count});
                    else
                        exp_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        word_t eh;
        if (chk_en) begin
            eh = (out_q.size() > 0) ? out_q[0] : '0;
            check("in_ready",  128'(o_sim_in_ready),  128'(in_q.size() < DEPTH));
            check("oh_ready",  128'(o_oh_ready),      128'(out_q.size() < DEPTH));
            check("out_valid", 128'(o_sim_out_valid), 128'(out_q.size() > 0));
            check("out_head",  128'({o_sim_out_status, o_sim_out_address, o_sim_out_data,
                                     o_sim_out_data_count}), 128'(eh));
            check("overflow",  128'(o_overflow),      128'(exp_ovf));
            check("ih_ready",  128'(o_ih_ready),      128'(exp_ih_ready));
            check("ih_reset",  128'(o_ih_reset),      128'(exp_ih_reset));
            check("in_fields", 128'({o_in_command, o_in_address, o_in_data,
                                     o_in_data_count}), 128'(exp_in));
        end
    end

    word_t issued[$];
    always @(negedge clk) begin
        if (o_ih_ready === 1'b1)
            issued.push_back({o_in_command, o_in_address, o_in_data, o_in_data_count});
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_cmd(input word_t w);
        i_sim_in_valid = 1'b1;
        {i_sim_in_command, i_sim_in_address, i_sim_in_data, i_sim_in_data_count} = w;
        cyc();
        i_sim_in_valid = 1'b0;
    endtask

    task automatic push_resp(input word_t w);
        i_oh_en = 1'b1;
        {i_out_status, i_out_address, i_out_data, i_out_data_count} = w;
        cyc();
        i_oh_en = 1'b0;
    endtask

    function automatic word_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [DW-1:0] c, input logic [CW-1:0] n);
        word_t w;
        w.a = a; w.b = b; w.c = c; w.n = n;
        return w;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst = 1'b1;
        i_sim_in_reset = 1'b0; i_sim_in_valid = 1'b0; i_sim_out_ready = 1'b0;
        i_master_ready = 1'b0; i_oh_en = 1'b0;
        i_sim_in_command = '0; i_sim_in_address = '0; i_sim_in_data = '0; i_sim_in_data_count = '0;
        i_out_status = '0; i_out_address = '0; i_out_data = '0; i_out_data_count = '0;
        repeat (3) cyc();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_in_ready",  128'(o_sim_in_ready),  128'(1));
        check("rst_oh_ready",  128'(o_oh_ready),      128'(1));
        check("rst_out_valid", 128'(o_sim_out_valid), 128'(0));
        check("rst_ih_ready",  128'(o_ih_ready),      128'(0));
        check("rst_overflow",  128'(o_overflow),      128'(0));
        check("rst_ih_reset",  128'(o_ih_reset),      128'(0));
        check("rst_in_cmd",    128'(o_in_command),    128'(0));

        // Single command: strobe two edges after the push edge
        i_master_ready = 1'b1;
        push_cmd(mk(32'h1, 32'h10, 32'hDEAD, 28'd1));
        check("single_e0_strobe", 128'(o_ih_ready), 128'(0));
        cyc();
        check("single_e1_strobe", 128'(o_ih_ready), 128'(0));
        cyc();
        check("single_e2_strobe", 128'(o_ih_ready), 128'(1));
        check("single_cmd",   128'(o_in_command),    128'(32'h1));
        check("single_addr",  128'(o_in_address),    128'(32'h10));
        check("single_data",  128'(o_in_data),       128'(32'hDEAD));
        check("single_count", 128'(o_in_data_count), 128'(1));
        cyc();
        check("single_e3_strobe", 128'(o_ih_ready), 128'(0));
        i_master_ready = 1'b0;
        repeat (2) cyc();

        // Queue fill: 4 accepted, 5th ignored, then exactly 4 issued in order
        for (int i = 0; i < 4; i++)
            push_cmd(mk(32'h20 + i, 32'h100 + i, 32'h5000 + i, 28'(i + 2)));
        check("fill_in_ready", 128'(o_sim_in_ready), 128'(0));
        push_cmd(mk(32'h99, 32'h999, 32'h9999, 28'd9));
        check("fill_in_ready_5th", 128'(o_sim_in_ready), 128'(0));
        issued.delete();
        for (int k = 0; k < 40; k++) begin
            i_master_ready = (k % 4 != 3);
            cyc();
        end
        i_master_ready = 1'b0;
        repeat (2) cyc();
        check("fill_issue_count", 128'(issued.size()), 128'(4));
        for (int i = 0; i < 4; i++)
            if (i < issued.size())
                check("fill_issue_cmd", 128'(issued[i].a), 128'(32'h20 + i));

        // Outbound FWFT ordering
        for (int i = 0; i < 3; i++)
            push_resp(mk(32'hA0 + i, 32'h200 + i, 32'hB00 + i, 28'(i)));
        check("out_valid3", 128'(o_sim_out_valid), 128'(1));
        check("out_first",  128'(o_sim_out_status), 128'(32'hA0));
        for (int i = 0; i < 3; i++) begin
            check("out_pop_status", 128'(o_sim_out_status), 128'(32'hA0 + i));
            check("out_pop_addr",   128'(o_sim_out_address), 128'(32'h200 + i));
            i_sim_out_ready = 1'b1;
            cyc();
            i_sim_out_ready = 1'b0;
        end
        check("out_drained", 128'(o_sim_out_valid), 128'(0));

        // Overflow: 5th response dropped, sticky until sim reset
        for (int i = 0; i < 4; i++)
            push_resp(mk(32'hE0 + i, 32'h0, 32'h0, 28'd0));
        check("ovf_before", 128'(o_overflow), 128'(0));
        check("ovf_oh_ready_full", 128'(o_oh_ready), 128'(0));
        push_resp(mk(32'hEF, 32'h0, 32'h0, 28'd0));
        check("ovf_set", 128'(o_overflow), 128'(1));
        repeat (3) cyc();
        check("ovf_sticky", 128'(o_overflow), 128'(1));
        check("ovf_head_kept", 128'(o_sim_out_status), 128'(32'hE0));
        i_sim_in_reset = 1'b1;
        cyc();
        i_sim_in_reset = 1'b0;
        check("ovf_cleared", 128'(o_overflow), 128'(0));
        check("ovf_flush_empty", 128'(o_sim_out_valid), 128'(0));
        check("ovf_ih_reset", 128'(o_ih_reset), 128'(1));
        cyc();
        check("ovf_ih_reset_drop", 128'(o_ih_reset), 128'(0));

        // Flush mid-HOLD with two commands still queued
        for (int i = 0; i < 3; i++)
            push_cmd(mk(32'h30 + i, 32'h300 + i, 32'h3000 + i, 28'd3));
        i_master_ready = 1'b1;
        repeat (3) cyc();
        i_sim_in_reset = 1'b1;
        cyc();
        i_sim_in_reset = 1'b0;
        check("flush_ih_reset", 128'(o_ih_reset), 128'(1));
        check("flush_in_ready", 128'(o_sim_in_ready), 128'(1));
        check("flush_in_kept", 128'(o_in_command), 128'(32'h30));
        issued.delete();
        for (int k = 0; k < 20; k++) begin
            i_master_ready = (k % 3 != 2);
            cyc();
        end
        check("flush_no_issue", 128'(issued.size()), 128'(0));
        i_master_ready = 1'b0;

        // Full outbound FIFO: simultaneous push and pop
        for (int i = 0; i < 4; i++)
            push_resp(mk(32'hC0 + i, 32'h400 + i, 32'h4000 + i, 28'd4));
        i_oh_en = 1'b1;
        {i_out_status, i_out_address, i_out_data, i_out_data_count} =
            mk(32'hC4, 32'h404, 32'h4004, 28'd4);
        i_sim_out_ready = 1'b1;
        cyc();
        i_oh_en = 1'b0;
        i_sim_out_ready = 1'b0;
        check("pp_oh_ready", 128'(o_oh_ready), 128'(0));
        check("pp_overflow", 128'(o_overflow), 128'(0));
        check("pp_head",     128'(o_sim_out_status), 128'(32'hC1));
        for (int i = 1; i < 5; i++) begin
            check("pp_drain", 128'(o_sim_out_status), 128'(32'hC0 + i));
            i_sim_out_ready = 1'b1;
            cyc();
            i_sim_out_ready = 1'b0;
        end
        check("pp_empty", 128'(o_sim_out_valid), 128'(0));

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            i_sim_in_valid      = ($urandom_range(0, 1) == 1);
            i_sim_in_command    = $urandom();
            i_sim_in_address    = $urandom();
            i_sim_in_data       = $urandom();
            i_sim_in_data_count = CW'($urandom());
            i_master_ready      = ($urandom_range(0, 9) < 6);
            i_oh_en             = ($urandom_range(0, 9) < 4);
            i_out_status        = $urandom();
            i_out_address       = $urandom();
            i_out_data          = $urandom();
            i_out_data_count    = CW'($urandom());
            i_sim_out_ready     = ($urandom_range(0, 1) == 1);
            i_sim_in_reset      = ($urandom_range(0, 49) == 0);
            cyc();
        end
        i_sim_in_valid = 1'b0; i_oh_en = 1'b0; i_sim_in_reset = 1'b0;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
